// File: rtl/gauss_jordan_solver_if.sv
// rtl/gauss_jordan_solver_if.sv - divider operand/quotient handshake bundle
interface gauss_jordan_solver_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] o_div_a;
  logic [DATA_WIDTH-1:0] o_div_b;
  logic                  o_div_stb;
  logic                  i_div_ack;
  logic [DATA_WIDTH-1:0] i_div_z;
  logic                  i_div_z_stb;
  logic                  o_div_z_ack;

  modport master (
    output o_div_a, o_div_b, o_div_stb, o_div_z_ack,
    input  i_div_ack, i_div_z, i_div_z_stb
  );

  modport slave (
    input  o_div_a, o_div_b, o_div_stb, o_div_z_ack,
    output i_div_ack, i_div_z, i_div_z_stb
  );
endinterface

// File: rtl/gauss_jordan_solver.sv
// rtl/gauss_jordan_solver.sv - Gauss-Jordan solver with partial pivoting, fixed point
module gauss_jordan_solver #(
  parameter int MATRIX_SIZE = 3,
  parameter int DATA_WIDTH  = 32,
  parameter int FRAC_BITS   = 16
) (
  input  logic                                           clk,
  input  logic                                           i_rst_n,
  input  logic                                           i_calc_cmd,
  input  logic [DATA_WIDTH*MATRIX_SIZE*(MATRIX_SIZE+1)-1:0] i_matrix,
  output logic [DATA_WIDTH*MATRIX_SIZE-1:0]              o_roots,
  output logic                                           o_ready,
  output logic                                           o_busy,
  output logic                                           o_singular,
  gauss_jordan_solver_if.master                          div
);
  localparam int N  = MATRIX_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int FB = FRAC_BITS;
  localparam int RW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam logic signed [DW-1:0] ONE  = {{(DW-1){1'b0}}, 1'b1} << FB;
  localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_SEARCH, S_SWAP, S_DIV_REQ, S_DIV_WAIT,
    S_ELIM_F, S_ELIM_OP, S_NEXT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic signed [DW-1:0] a [N][N+1];
  logic [RW-1:0]        k, r, piv, i, next_i;
  logic [CW-1:0]        j, kc;
  logic [DW:0]          max_abs, cur_abs, new_max;
  logic signed [DW:0]   cur_ext;
  logic signed [DW-1:0] f, elim_res;
  logic signed [2*DW-1:0] fx, ax, prod, prod_sh;
  logic [2*DW:0]        diff;
  logic [DW+1:0]        diff_hi;
  logic [RW:0]          ni_w;
  logic                 elim_last;

  assign kc = CW'(k);

  // pivot magnitude of the row being scanned, widened so the most negative value has a magnitude
  always_comb begin
    cur_ext = {a[r][kc][DW-1], a[r][kc]};
    cur_abs = cur_ext[DW] ? -cur_ext : cur_ext;
    new_max = (cur_abs > max_abs) ? cur_abs : max_abs;
  end

  // multiply-subtract with full-width product, arithmetic shift and saturation
  always_comb begin
    fx       = {{DW{f[DW-1]}}, f};
    ax       = {{DW{a[k][j][DW-1]}}, a[k][j]};
    prod     = fx * ax;
    prod_sh  = prod >>> FB;
    diff     = {{(DW+1){a[i][j][DW-1]}}, a[i][j]} - {prod_sh[2*DW-1], prod_sh};
    diff_hi  = diff[2*DW:DW-1];
    if ((diff_hi == '0) || (diff_hi == '1)) begin
      elim_res = diff[DW-1:0];
    end else begin
      elim_res = diff[2*DW] ? MINV : MAXV;
    end
  end

  // next row to eliminate, skipping the pivot row
  always_comb begin
    ni_w = {1'b0, i} + (RW+1)'(1);
    if (ni_w == {1'b0, k}) begin
      ni_w = ni_w + (RW+1)'(1);
    end
    elim_last = (ni_w >= (RW+1)'(N));
    next_i    = ni_w[RW-1:0];
  end

  // state register
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (i_calc_cmd) state_nxt = S_SEARCH;
      S_SEARCH:   if (r == RW'(N - 1)) state_nxt = (new_max == '0) ? S_DONE : S_SWAP;
      S_SWAP:     state_nxt = S_DIV_REQ;
      S_DIV_REQ:  if (div.i_div_ack) state_nxt = S_DIV_WAIT;
      S_DIV_WAIT: if (div.i_div_z_stb) state_nxt = (j == CW'(N)) ? S_ELIM_F : S_DIV_REQ;
      S_ELIM_F:   state_nxt = S_ELIM_OP;
      S_ELIM_OP:  if (j == CW'(N)) state_nxt = elim_last ? S_NEXT : S_ELIM_F;
      S_NEXT:     state_nxt = (k == RW'(N - 1)) ? S_DONE : S_SEARCH;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // divider handshake is driven straight from state so operands stay stable while stalled
  always_comb begin
    div.o_div_stb   = 1'b0;
    div.o_div_a     = '0;
    div.o_div_b     = '0;
    div.o_div_z_ack = 1'b0;
    if (state == S_DIV_REQ) begin
      div.o_div_stb = 1'b1;
      div.o_div_a   = a[k][j];
      div.o_div_b   = a[k][kc];
    end
    if (state == S_DIV_WAIT) begin
      div.o_div_z_ack = div.i_div_z_stb;
    end
  end

  // working array, loop counters and result registers
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int rr = 0; rr < N; rr++) begin
        for (int cc = 0; cc <= N; cc++) begin
          a[rr][cc] <= '0;
        end
      end
      k          <= '0;
      r          <= '0;
      piv        <= '0;
      i          <= '0;
      j          <= '0;
      f          <= '0;
      max_abs    <= '0;
      o_roots    <= '0;
      o_ready    <= 1'b0;
      o_busy     <= 1'b0;
      o_singular <= 1'b0;
    end else begin
      o_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_calc_cmd) begin
            for (int rr = 0; rr < N; rr++) begin
              for (int cc = 0; cc <= N; cc++) begin
                a[rr][cc] <= i_matrix[DW*(rr*(N+1)+cc) +: DW];
              end
            end
            k          <= '0;
            r          <= '0;
            piv        <= '0;
            max_abs    <= '0;
            o_busy     <= 1'b1;
            o_singular <= 1'b0;
          end
        end
        S_SEARCH: begin
          if (cur_abs > max_abs) begin
            max_abs <= cur_abs;
            piv     <= r;
          end
          r <= r + RW'(1);
          if ((r == RW'(N - 1)) && (new_max == '0)) begin
            o_singular <= 1'b1;
          end
        end
        S_SWAP: begin
          if (piv != k) begin
            for (int cc = 0; cc <= N; cc++) begin
              a[k][cc]   <= a[piv][cc];
              a[piv][cc] <= a[k][cc];
            end
          end
          j <= kc + CW'(1);
        end
        S_DIV_WAIT: begin
          if (div.i_div_z_stb) begin
            a[k][j] <= div.i_div_z;
            if (j == CW'(N)) begin
              a[k][kc] <= ONE;
              i        <= (k == '0) ? RW'(1) : '0;
            end else begin
              j <= j + CW'(1);
            end
          end
        end
        S_ELIM_F: begin
          f <= a[i][kc];
          j <= kc;
        end
        S_ELIM_OP: begin
          a[i][j] <= elim_res;
          if (j == CW'(N)) begin
            i <= next_i;
          end else begin
            j <= j + CW'(1);
          end
        end
        S_NEXT: begin
          if (k != RW'(N - 1)) begin
            k       <= k + RW'(1);
            r       <= k + RW'(1);
            piv     <= k + RW'(1);
            max_abs <= '0;
          end
        end
        S_DONE: begin
          for (int rr = 0; rr < N; rr++) begin
            o_roots[DW*rr +: DW] <= a[rr][N];
          end
          o_ready <= 1'b1;
          o_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gauss_jordan_solver.sv
// tb/tb_gauss_jordan_solver.sv - table-driven scoreboard bench for gauss_jordan_solver
module tb_gauss_jordan_solver;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int FB = 16;

  typedef struct {
    logic [DW*N*(N+1)-1:0] matrix;
    logic [DW*N-1:0]       roots;
    logic                  singular;
    int                    ack_dly;
    int                    z_dly;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  cmd;
  logic [DW*N*(N+1)-1:0] matrix;
  logic [DW*N-1:0]       roots;
  logic                  ready, busy, singular;

  int   n_vec = 0;
  int   n_err = 0;
  int   ready_cnt = 0;
  int   zack_cnt = 0;
  int   ack_dly = 0;
  int   z_dly = 0;
  vec_t exp_q[$];
  vec_t vecs[7];
  vec_t e_pop;
  logic prev_busy = 1'b0;
  logic stalled = 1'b0;
  logic [DW-1:0] held_a, held_b;

  always #5 clk = ~clk;

  gauss_jordan_solver_if #(.DATA_WIDTH(DW)) dif ();

  gauss_jordan_solver #(
    .MATRIX_SIZE(N), .DATA_WIDTH(DW), .FRAC_BITS(FB)
  ) u_dut (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_calc_cmd (cmd),
    .i_matrix   (matrix),
    .o_roots    (roots),
    .o_ready    (ready),
    .o_busy     (busy),
    .o_singular (singular),
    .div        (dif.master)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW*N*(N+1)-1:0] pack(input int e[12]);
    logic [DW*N*(N+1)-1:0] m;
    m = '0;
    for (int x = 0; x < 12; x++) m[DW*x +: DW] = e[x] <<< FB;
    return m;
  endfunction

  // divider model: programmable accept and result latency, Q-format quotient
  initial begin
    int phase;
    int cnt;
    logic signed [DW-1:0] da, db;
    longint q;
    phase = 0;
    cnt = 0;
    da = '0;
    db = '0;
    dif.i_div_ack   = 1'b0;
    dif.i_div_z_stb = 1'b0;
    dif.i_div_z     = '0;
    forever begin
      @(posedge clk);
      #1;
      dif.i_div_ack = 1'b0;
      if (!rst_n) begin
        dif.i_div_z_stb = 1'b0;
        phase = 0;
        cnt = 0;
      end else begin
        case (phase)
          0: if (dif.o_div_stb) begin
               if (cnt >= ack_dly) begin
                 dif.i_div_ack = 1'b1;
                 da = dif.o_div_a;
                 db = dif.o_div_b;
                 cnt = 0;
                 phase = 1;
               end else cnt++;
             end
          1: if (cnt >= z_dly) begin
               q = (longint'(da) <<< FB) / longint'(db);
               dif.i_div_z = q[DW-1:0];
               dif.i_div_z_stb = 1'b1;
               phase = 2;
             end else cnt++;
          default: begin
            dif.i_div_z_stb = 1'b0;
            phase = 0;
            cnt = 0;
          end
        endcase
      end
    end
  end

  // monitor: handshake rules, operand stability, scoreboard pop on o_ready
  always @(negedge clk) begin
    if (rst_n) begin
      if (dif.i_div_z_stb || dif.o_div_z_ack) check("z_ack with z_stb", dif.o_div_z_ack, dif.i_div_z_stb);
      if (dif.o_div_z_ack) zack_cnt++;
      if (dif.o_div_stb) begin
        if (stalled) begin
          check("div_a stable", dif.o_div_a, held_a);
          check("div_b stable", dif.o_div_b, held_b);
        end
        held_a  = dif.o_div_a;
        held_b  = dif.o_div_b;
        stalled = !dif.i_div_ack;
      end else begin
        stalled = 1'b0;
      end
      if (ready) begin
        ready_cnt++;
        check("busy low with ready", busy, 1'b0);
        check("busy high before ready", prev_busy, 1'b1);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected o_ready: got 1 expected 0");
        end else begin
          e_pop = exp_q.pop_front();
          check("singular", singular, e_pop.singular);
          if (!e_pop.singular) begin
            for (int x = 0; x < N; x++)
              check($sformatf("root%0d", x), roots[DW*x +: DW], e_pop.roots[DW*x +: DW]);
          end
        end
      end
    end
    prev_busy = busy;
  end

  task automatic wait_ready(input int start);
    int t;
    t = 0;
    while (ready_cnt == start && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (ready_cnt == start) begin
      n_vec++;
      n_err++;
      $display("FAIL ready timeout: got no o_ready expected one");
      exp_q.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    int start;
    ack_dly = v.ack_dly;
    z_dly   = v.z_dly;
    @(negedge clk);
    matrix = v.matrix;
    cmd = 1'b1;
    start = ready_cnt;
    exp_q.push_back(v);
    @(negedge clk);
    cmd = 1'b0;
    check("busy after cmd", busy, 1'b1);
    wait_ready(start);
    repeat (3) @(negedge clk);
    if (!v.singular) check("roots hold", roots, v.roots);
  endtask

  initial begin
    int e[12];
    int start;
    int t;
    rst_n = 1'b0;
    cmd = 1'b0;
    matrix = '0;

    e = '{2,0,0,4, 0,4,0,8, 0,0,1,5};
    vecs[0] = '{pack(e), {32'h00050000, 32'h00020000, 32'h00020000}, 1'b0, 0, 0};
    e = '{0,1,0,2, 1,0,0,3, 0,0,2,8};
    vecs[1] = '{pack(e), {32'h00040000, 32'h00020000, 32'h00030000}, 1'b0, 0, 0};
    e = '{1,0,0,1, 1,1,1,3, 1,1,1,3};
    vecs[2] = '{pack(e), '0, 1'b1, 0, 0};
    e = '{2,0,0,4, 0,4,0,8, 0,0,1,5};
    vecs[3] = '{pack(e), {32'h00050000, 32'h00020000, 32'h00020000}, 1'b0, 5, 7};
    e = '{0,1,0,2, 1,0,0,3, 0,0,2,8};
    vecs[4] = '{pack(e), {32'h00040000, 32'h00020000, 32'h00030000}, 1'b0, 5, 7};
    e = '{-2,4,0,-10, 0,1,2,4, 0,0,-4,-12};
    vecs[5] = '{pack(e), {32'h00030000, 32'hFFFE0000, 32'h00010000}, 1'b0, 1, 2};
    e = '{2,0,0,1, 0,-4,0,2, 0,0,8,-1};
    vecs[6] = '{pack(e), {32'hFFFFE000, 32'hFFFF8000, 32'h00008000}, 1'b0, 0, 3};

    repeat (3) @(negedge clk);
    check("reset roots", roots, '0);
    check("reset ready", ready, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset singular", singular, 1'b0);
    check("reset div_stb", dif.o_div_stb, 1'b0);
    check("reset div_a", dif.o_div_a, '0);
    check("reset div_b", dif.o_div_b, '0);
    check("reset z_ack", dif.o_div_z_ack, 1'b0);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) run_vec(vecs[v]);

    // command re-pulsed while busy is ignored
    ack_dly = 2;
    z_dly = 2;
    @(negedge clk);
    matrix = vecs[1].matrix;
    cmd = 1'b1;
    start = ready_cnt;
    exp_q.push_back(vecs[1]);
    @(negedge clk);
    cmd = 1'b0;
    repeat (8) @(negedge clk);
    matrix = vecs[0].matrix;
    cmd = 1'b1;
    @(negedge clk);
    cmd = 1'b0;
    wait_ready(start);
    repeat (300) @(negedge clk);
    check("single ready pulse", ready_cnt - start, 1);

    // reset while eliminating column 0
    ack_dly = 0;
    z_dly = 0;
    @(negedge clk);
    matrix = vecs[0].matrix;
    cmd = 1'b1;
    start = zack_cnt;
    @(negedge clk);
    cmd = 1'b0;
    t = 0;
    while (zack_cnt - start < 3 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("third quotient seen", zack_cnt - start, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort roots", roots, '0);
    check("abort busy", busy, 1'b0);
    check("abort singular", singular, 1'b0);
    check("abort ready", ready, 1'b0);
    check("abort div_stb", dif.o_div_stb, 1'b0);
    check("abort z_ack", dif.o_div_z_ack, 1'b0);
    start = ready_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("no ready after abort", ready_cnt - start, 0);
    check("idle busy after abort", busy, 1'b0);
    run_vec(vecs[5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
